// File: rtl/vld_ram_drain.sv
// Read-side sweeper for the valid-tagged buffer: walks port B, emits every valid
// entry once on a valid/ready stream, then clears it so the buffer ends empty.
`timescale 1ns/1ps

module vld_ram_drain #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_ADDR_BITS = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_ADDR_BITS-1:0] ram_addrb,
  output logic                     ram_web,
  output logic [PAYLOAD_BITS:0]    ram_dinb,
  input  logic [PAYLOAD_BITS:0]    ram_doutb,
  output logic [PAYLOAD_BITS-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_ADDR_BITS:0]   out_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_SEND,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [NUM_ADDR_BITS-1:0] idx;
  logic                     last_idx;
  logic                     entry_valid;

  // The end test looks at the current index, so idx never has to wrap.
  assign last_idx    = &idx;
  assign entry_valid = ram_doutb[PAYLOAD_BITS];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_CHECK;
      S_CHECK: begin
        if (entry_valid)   state_nxt = S_SEND;
        else if (last_idx) state_nxt = S_DONE;
        else               state_nxt = S_ISSUE;
      end
      S_SEND:  if (out_ready) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = last_idx ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode state only; out_ready never reaches an output combinationally.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    ram_web   = (state == S_CLEAR);
    out_valid = (state == S_SEND);
  end

  assign ram_addrb = idx;
  assign ram_dinb  = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      out_count <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= '0;
            out_count <= '0;
          end
        end
        S_CHECK: begin
          if (entry_valid)    out_data <= ram_doutb[PAYLOAD_BITS-1:0];
          else if (!last_idx) idx      <= idx + 1'b1;
        end
        S_SEND: begin
          if (out_ready) out_count <= out_count + 1'b1;
        end
        S_CLEAR: begin
          if (!last_idx) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vld_ram_drain.sv
// Bench for vld_ram_drain: a two-port buffer model, table-driven sweeps, hand-written
// corner sequences and randomized sweeps checked against a queue-based reference.
`timescale 1ns/1ps

module tb_vld_ram_drain;

  localparam int PB    = 32;
  localparam int AB    = 7;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AB-1:0] ram_addrb;
  logic          ram_web;
  logic [PB:0]   ram_dinb;
  logic [PB:0]   ram_doutb;
  logic [PB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AB:0]   out_count;

  // Upstream writer on port A
  logic          wea;
  logic [AB-1:0] addra;
  logic [PB:0]   dina;

  int total = 0;
  int bad   = 0;

  logic [PB:0] mem [DEPTH];
  logic [PB:0] img [DEPTH];
  logic [PB-1:0] exp_pay[$];
  int            exp_addr[$];

  typedef struct {
    logic [DEPTH-1:0] mask;
    int               pct;
    int               hold;
    int               exp_done;
    int               exp_count;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  vld_ram_drain #(.PAYLOAD_BITS(PB), .NUM_ADDR_BITS(AB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_addrb (ram_addrb),
    .ram_web   (ram_web),
    .ram_dinb  (ram_dinb),
    .ram_doutb (ram_doutb),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  // Buffer model: registered port-B read; port A wins a same-address collision.
  always @(posedge clk) begin
    if (ram_web) mem[ram_addrb] <= ram_dinb;
    if (wea)     mem[addra]     <= dina;
    ram_doutb <= mem[ram_addrb];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_mask(input logic [DEPTH-1:0] mask);
    logic [PB-1:0] pay;
    for (int a = 0; a < DEPTH; a++) begin
      pay = $urandom;
      if (a == 0)   pay = 32'h11;
      if (a == 5)   pay = 32'h55;
      if (a == 127) pay = 32'h7F;
      img[a] = {mask[a], pay};
      @(negedge clk);
      wea   = 1'b1;
      addra = AB'(a);
      dina  = img[a];
    end
    @(negedge clk);
    wea = 1'b0;
  endtask

  // Reference: every valid entry, ascending address, exactly once.
  task automatic build_model(output int n);
    exp_pay.delete();
    exp_addr.delete();
    for (int a = 0; a < DEPTH; a++) begin
      if (img[a][PB]) begin
        exp_pay.push_back(img[a][PB-1:0]);
        exp_addr.push_back(a);
      end
    end
    n = exp_pay.size();
  endtask

  task automatic check_mem(input int keep);
    int left;
    left = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (a != keep && mem[a][PB]) left++;
    end
    check("valid_left", left, 0);
    if (keep >= 0) check("collide_kept", mem[keep], {1'b1, 32'hAA});
  endtask

  // One sweep: cycle k is the cycle after the k-th edge following the start edge.
  task automatic sweep(input int pct, input int hold, input bit extra_start, input int collide,
                       output int done_at, output int stalls);
    int            vrun;
    int            ndone;
    int            last_addr;
    bit            acc_prev;
    bit            fin;
    logic [PB-1:0] held;
    done_at   = -1;
    stalls    = 0;
    vrun      = 0;
    ndone     = 0;
    last_addr = -1;
    acc_prev  = 1'b0;
    fin       = 1'b0;
    held      = '0;
    start     = 1'b1;
    for (int k = 1; k <= 2000 && !fin; k++) begin
      @(negedge clk);
      start = (extra_start && k == 1);
      wea   = 1'b0;
      if (k == 1) check("busy_rise", busy, 1);
      if (ram_web) begin
        check("web_after_accept", acc_prev, 1);
        check("web_addr", ram_addrb, last_addr);
        check("dinb_zero", ram_dinb, 0);
        if (ram_addrb == collide) begin
          wea   = 1'b1;
          addra = AB'(collide);
          dina  = {1'b1, 32'hAA};
        end
      end
      if (out_valid) begin
        if (vrun > 0) check("data_stable", out_data, held);
        held = out_data;
      end
      out_ready = out_valid ? (vrun >= hold && $urandom_range(99) < pct) : 1'($urandom_range(1));
      acc_prev  = out_valid && out_ready;
      if (out_valid && !out_ready) stalls++;
      if (acc_prev) begin
        if (exp_pay.size() == 0) check("extra_emit", 1, 0);
        else begin
          check("emit_data", out_data, exp_pay.pop_front());
          last_addr = exp_addr.pop_front();
        end
      end
      vrun = out_valid ? vrun + 1 : 0;
      if (done_at >= 0 && k == done_at + 1) begin
        check("busy_fall", busy, 0);
        check("done_one_cycle", done, 0);
        fin = 1'b1;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
        if (extra_start) start = 1'b1;
      end
    end
    start     = 1'b0;
    out_ready = 1'b0;
    wea       = 1'b0;
    if (!fin) check("sweep_timeout", 0, 1);
    check("missing_emit", exp_pay.size(), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy || done) ndone += 10;
    end
    check("done_pulses", ndone, 1);
  endtask

  initial begin
    int n;
    int done_at;
    int stalls;
    int dens;
    int pct;
    int hold;
    bit seen;
    bit found;
    logic [DEPTH-1:0] m;

    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    wea       = 1'b0;
    addra     = '0;
    dina      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addrb", ram_addrb, 0);
    check("rst_web", ram_web, 0);
    check("rst_dinb", ram_dinb, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    reset = 1'b0;

    vecs[0] = '{mask: '0, pct: 100, hold: 0, exp_done: 257, exp_count: 0};
    vecs[1] = '{mask: (128'h1 << 127) | 128'h21, pct: 100, hold: 0, exp_done: 263, exp_count: 3};
    vecs[2] = '{mask: {DEPTH{1'b1}}, pct: 100, hold: 0, exp_done: 513, exp_count: 128};
    vecs[3] = '{mask: 128'h1 << 64, pct: 100, hold: 0, exp_done: 259, exp_count: 1};
    vecs[4] = '{mask: 128'h8, pct: 100, hold: 10, exp_done: 269, exp_count: 1};

    foreach (vecs[i]) begin
      load_mask(vecs[i].mask);
      build_model(n);
      sweep(vecs[i].pct, vecs[i].hold, 1'b0, -1, done_at, stalls);
      check("tbl_done_cycle", done_at, vecs[i].exp_done);
      check("tbl_out_count", out_count, vecs[i].exp_count);
      check_mem(-1);
    end

    // Port-A write lands on the entry in its own clear cycle.
    load_mask((128'h1 << 9) | (128'h1 << 5) | (128'h1 << 2));
    build_model(n);
    sweep(100, 0, 1'b0, 5, done_at, stalls);
    check("col_done_cycle", done_at, 263);
    check("col_out_count", out_count, 3);
    check_mem(5);

    // Extra start pulses in ISSUE and in DONE.
    load_mask((128'h1 << 100) | 128'h2);
    build_model(n);
    sweep(100, 0, 1'b1, -1, done_at, stalls);
    check("xs_done_cycle", done_at, 261);
    check("xs_out_count", out_count, 2);

    // Reset while the second entry sits unacknowledged in SEND.
    load_mask((128'h1 << 9) | 128'h4);
    seen  = 1'b0;
    found = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && seen) found = 1'b1;
      out_ready = out_valid && !seen;
      if (out_valid && !seen) seen = 1'b1;
    end
    check("reach_second_send", found, 1);
    check("pre_rst_count", out_count, 1);
    check("pre_rst_data", out_data, img[9][PB-1:0]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_count", out_count, 0);
    check("mid_rst_addrb", ram_addrb, 0);
    check("mid_rst_web", ram_web, 0);
    check("mid_rst_kept", mem[9][PB], 1);
    check("mid_rst_cleared", mem[2][PB], 0);
    img[2] = '0;
    build_model(n);
    sweep(100, 0, 1'b0, -1, done_at, stalls);
    check("post_rst_done_cycle", done_at, 259);
    check("post_rst_count", out_count, 1);
    check_mem(-1);

    // Randomized sweeps with random occupancy and random backpressure.
    for (int it = 0; it < 6; it++) begin
      dens = $urandom_range(60);
      pct  = $urandom_range(100, 40);
      hold = $urandom_range(3);
      for (int b = 0; b < DEPTH; b++) m[b] = ($urandom_range(99) < dens);
      load_mask(m);
      build_model(n);
      sweep(pct, hold, 1'b0, -1, done_at, stalls);
      check("rnd_done_cycle", done_at, 1 + 2 * DEPTH + 2 * n + stalls);
      check("rnd_out_count", out_count, n);
      check_mem(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vld_ram_drain.md
# vld_ram_drain

Read-side sweeper for the valid-tagged single-port-pair buffer used in the z-culling output stage. On `start`, it walks every address of the buffer's read port B in ascending order. Each entry whose valid bit (bit `PAYLOAD_BITS`) is set is emitted once on a valid/ready output stream, then cleared through the buffer's B write port. The buffer is thereby empty when `done` pulses. It sits between the buffer and the downstream output FIFO/packetizer; port A of the buffer stays owned by the upstream writer.

## Interface
Parameters:
- `PAYLOAD_BITS`, 32, data width excluding the valid bit
- `NUM_ADDR_BITS`, 7, buffer address width; sweep covers 0 .. 2^NUM_ADDR_BITS-1

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a sweep; ignored unless state is IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the sweep completes
- `ram_addrb`  out  NUM_ADDR_BITS  buffer port-B address (read and clear)
- `ram_web`  out  1  buffer port-B write enable (clear strobe)
- `ram_dinb`  out  PAYLOAD_BITS+1  buffer port-B write data; constant 0
- `ram_doutb`  in  PAYLOAD_BITS+1  buffer port-B read data; registered, valid one cycle after `ram_addrb`
- `out_data`  out  PAYLOAD_BITS  emitted payload
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`
- `out_count`  out  NUM_ADDR_BITS+1  entries emitted in the current or last sweep

## Operation
- The FSM has six states: IDLE, ISSUE, CHECK, SEND, CLEAR, DONE. An index register `idx` of `NUM_ADDR_BITS` bits drives `ram_addrb` at all times.
- **IDLE:** if `start`, then `idx` ← 0, `out_count` ← 0, and the FSM goes to ISSUE.
- **ISSUE:** `ram_addrb` = `idx` is presented to the buffer. The FSM always goes to CHECK.
- **CHECK:** `ram_doutb` now holds entry `idx`.
  - If `ram_doutb[PAYLOAD_BITS]` = 1: `out_data` ← `ram_doutb[PAYLOAD_BITS-1:0]`, and the FSM goes to SEND.
  - Otherwise the FSM goes to DONE if `idx` = all-ones. If not, `idx` ← `idx`+1 and the FSM goes to ISSUE.
- **SEND:** `out_valid` = 1 while `out_data` is held stable. When `out_ready` = 1, `out_count` ← `out_count`+1 and the FSM goes to CLEAR. `out_valid` must not drop before the handshake completes.
- **CLEAR:** `ram_web` = 1 and `ram_dinb` = 0 at address `idx`. Next state follows the same end test as CHECK-invalid: DONE at the last index, otherwise increment `idx` and go to ISSUE.
- **DONE:** `done` = 1 for this one cycle, then the FSM goes to IDLE. `out_count` holds its value until the next `start`.
- `start` is ignored in all states other than IDLE, including DONE.
- `idx` never wraps during a sweep. The end test uses `idx` = 2^NUM_ADDR_BITS-1, so there is no increment overflow.
- There is no arbitration with port A.
  - If the writer hits the same address in the CLEAR cycle, port A's data wins. That entry is not re-emitted in this sweep, because `idx` has already passed it.
  - Port A writes to addresses above `idx` are picked up in the current sweep.
- `reset` at any time: state ← IDLE, `idx` ← 0, `out_count` ← 0. The partially emitted entry is dropped and the buffer is not cleared.

## Timing
- Reset values: `busy` 0, `done` 0, `ram_addrb` 0, `ram_web` 0, `ram_dinb` 0, `out_data` 0, `out_valid` 0, `out_count` 0.
- All outputs are registered or decoded from state only. There is no combinational path from `out_ready` to any output.
- Read latency: 1 cycle, from `ram_addrb` in ISSUE to the `ram_doutb` sample in CHECK.
- Cost per entry: invalid entry 2 cycles; valid entry 4 cycles plus SEND stall cycles.
- `start` sampled at edge t: `busy` = 1 from t+1. For N valid entries with `out_ready` held at 1, `done` is high in cycle t+1+2·2^NUM_ADDR_BITS+2N. `busy` falls one cycle after `done`.
- `out_valid` rises the cycle after CHECK and falls the cycle after the accepting edge.
- `ram_web` is high for exactly one cycle per emitted entry.

## Test plan
- **Empty buffer** (all 128 valid bits 0), `start` at t: no `out_valid` and no `ram_web`; `done` at t+257; `out_count` = 0.
- **Addresses 0, 5, 127 valid** with payloads 0x11, 0x55, 0x7F, `out_ready` = 1: outputs in that order; `done` at t+263; `out_count` = 3; afterwards every valid bit reads 0.
- **Backpressure:** entry 3 valid, `out_ready` low for 10 cycles: `out_valid` stays high with `out_data` stable; exactly one transfer; `ram_web` is asserted only after the accepting edge.
- **Port-A collision:** writer writes address 5 with valid = 1, data 0xAA in the CLEAR cycle for `idx` = 5: the entry remains valid with 0xAA and is not emitted again in the sweep.
- **Reset mid-SEND:** assert `reset` while `out_valid` = 1: the next cycle shows IDLE with all outputs 0, and the unacknowledged entry is still valid in the buffer.
- **Extra `start` pulses:** pulsed during ISSUE and during DONE: ignored; exactly one sweep and one `done` pulse.
